// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT bridge driver: FSM encoding, mode/phase constants, gate decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package swipt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STOP  = 3'd2,
        FAULT = 3'd3
    } state_e;

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_HALF = 1'b1;

    localparam logic PHASE_A = 1'b0;
    localparam logic PHASE_B = 1'b1;

    // Gate pattern for one clock of switching. 'on' is false during the
    // dead-time window so both legs are guaranteed off across a phase change.
    // Bits 0..3 drive s1..s4.
    function automatic logic [3:0] gate_decode(input logic phase, input logic on, input logic mode);
        logic [3:0] g;
        g = 4'b0000;
        if (phase == PHASE_A) begin
            g[0] = on;
            if (mode == MODE_FULL) begin
                g[3] = on;
            end
        end else begin
            g[1] = on;
            if (mode == MODE_FULL) begin
                g[2] = on;
            end
        end
        // Half-bridge parks the second leg with s4 permanently closed.
        if (mode == MODE_HALF) begin
            g[3] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/swipt_heartbeat_wdt.sv
// Heartbeat watchdog: o_alive rises on any heartbeat edge, falls after HB_TIMEOUT quiet clocks.
// Latency: o_alive is registered, 1 clock after the edge / timeout is seen.
// Backpressure: none; free-running monitor.
module swipt_heartbeat_wdt #(
    parameter int HB_TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_heartbeat,
    output logic o_alive
);

    localparam int WDT_W = $clog2(HB_TIMEOUT + 1);
    localparam logic [WDT_W-1:0] TIMEOUT_CNT = WDT_W'(HB_TIMEOUT);

    logic             hb_prev_q;
    logic             hb_edge;
    logic [WDT_W-1:0] wdt_cnt_q;
    logic [WDT_W-1:0] wdt_cnt_d;
    logic             alive_q;
    logic             alive_d;

    // Previous heartbeat sample runs through reset so release never sees a stale level as an edge.
    always_ff @(posedge clk) begin
        hb_prev_q <= i_heartbeat;
    end

    // Edge restarts the quiet-time count; the counter saturates at the timeout and drops alive.
    always_comb begin
        hb_edge   = i_heartbeat ^ hb_prev_q;
        wdt_cnt_d = wdt_cnt_q;
        alive_d   = alive_q;
        if (hb_edge) begin
            wdt_cnt_d = '0;
            alive_d   = 1'b1;
        end else if (wdt_cnt_q < TIMEOUT_CNT) begin
            wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
        end else begin
            alive_d = 1'b0;
        end
    end

    // Counter and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wdt_cnt_q <= '0;
            alive_q   <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            alive_q   <= alive_d;
        end
    end

    assign o_alive = alive_q;

endmodule

// File: rtl/swipt_bridge_driver.sv
// H-bridge gate sequencer with dead-time, graceful stop at period end and heartbeat-driven fault.
// Latency: o_gate is 1 clock behind the cnt/phase decode; forced off on the edge that leaves RUN/STOP.
// Backpressure: none; new half-periods are only accepted at full-period boundaries.
module swipt_bridge_driver
    import swipt_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DEADTIME_CYC = 10,
    parameter int HB_TIMEOUT   = 1000000
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_half_period,
    input  logic             i_mode,
    input  logic             i_heartbeat,
    output logic [3:0]       o_gate,
    output logic             o_alive,
    output logic             o_range_err,
    output logic [2:0]       o_state,
    output logic [31:0]      o_period_cnt
);

    localparam logic [CNT_W-1:0] DT = CNT_W'(DEADTIME_CYC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic             phase_q, phase_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;
    logic [31:0]      pcnt_q, pcnt_d;
    logic [3:0]       gate_q, gate_d;

    logic alive;
    logic hp_valid;
    logic cnt_wrap;
    logic period_end;
    logic active_q;
    logic active_d;

    swipt_heartbeat_wdt #(
        .HB_TIMEOUT (HB_TIMEOUT)
    ) u_wdt (
        .clk         (clk),
        .nrst        (nrst),
        .i_heartbeat (i_heartbeat),
        .o_alive     (alive)
    );

    assign hp_valid   = (DT < i_half_period);
    assign cnt_wrap   = (cnt_q == (hp_q - CNT_W'(1)));
    assign period_end = cnt_wrap && (phase_q == PHASE_B);
    assign active_q   = (state_q == RUN) || (state_q == STOP);
    assign active_d   = (state_d == RUN) || (state_d == STOP);

    // State and datapath registers; reset drops the gates on the same edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hp_q    <= '0;
            phase_q <= PHASE_A;
            mode_q  <= MODE_FULL;
            err_q   <= 1'b0;
            pcnt_q  <= '0;
            gate_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            pcnt_q  <= pcnt_d;
            gate_q  <= gate_d;
        end
    end

    // Next state: watchdog loss wins, stop requests finish the current full period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        err_d   = err_q;
        pcnt_d  = pcnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_enable && alive) begin
                    if (hp_valid) begin
                        state_d = RUN;
                        hp_d    = i_half_period;
                        mode_d  = i_mode;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN, STOP: begin
                if (!alive) begin
                    state_d = FAULT;
                end else begin
                    if (cnt_wrap) begin
                        cnt_d   = '0;
                        phase_d = ~phase_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (period_end) begin
                        pcnt_d = pcnt_q + 32'd1;
                        if ((state_q == STOP) || !i_enable) begin
                            state_d = IDLE;
                            err_d   = 1'b0;
                        end else if (hp_valid) begin
                            hp_d = i_half_period;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if ((state_q == RUN) && !i_enable) begin
                        state_d = STOP;
                    end
                end
            end
            FAULT: begin
                if (!i_enable && alive) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outside switching the sequencer always waits at the start of phase A.
        if ((state_d == IDLE) || (state_d == FAULT)) begin
            cnt_d   = '0;
            phase_d = PHASE_A;
        end
    end

    // Gate decode of the present cnt/phase, blanked whenever this edge leaves or has not entered switching.
    always_comb begin
        gate_d = 4'b0000;
        if (active_q && active_d) begin
            gate_d = gate_decode(phase_q, (cnt_q >= DT), mode_q);
        end
    end

    assign o_gate       = gate_q;
    assign o_alive      = alive;
    assign o_range_err  = err_q;
    assign o_state      = state_q;
    assign o_period_cnt = pcnt_q;

endmodule

// File: tb/tb_swipt_bridge_driver.sv
// Bench for swipt_bridge_driver: full-bridge (DT=4) and half-bridge (DT=2) instances against a position-based model.
// Latency: model predicts registered outputs cycle by cycle.
// Backpressure: n/a.
module tb_swipt_bridge_driver;

    localparam int CNT_W = 16;
    localparam int HB_T  = 100;
    localparam int DT0   = 4;
    localparam int DT1   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             nrst;
    logic             hb;
    logic             en      [2];
    logic [CNT_W-1:0] hp_in   [2];
    logic             mode_in [2];
    logic [3:0]       gate_o  [2];
    logic             alive_o [2];
    logic             err_o   [2];
    logic [2:0]       state_o [2];
    logic [31:0]      pcnt_o  [2];

    swipt_bridge_driver #(.CNT_W(CNT_W), .DEADTIME_CYC(DT0), .HB_TIMEOUT(HB_T)) dut0 (
        .clk(clk), .nrst(nrst), .i_enable(en[0]), .i_half_period(hp_in[0]), .i_mode(mode_in[0]),
        .i_heartbeat(hb), .o_gate(gate_o[0]), .o_alive(alive_o[0]), .o_range_err(err_o[0]),
        .o_state(state_o[0]), .o_period_cnt(pcnt_o[0])
    );

    swipt_bridge_driver #(.CNT_W(CNT_W), .DEADTIME_CYC(DT1), .HB_TIMEOUT(HB_T)) dut1 (
        .clk(clk), .nrst(nrst), .i_enable(en[1]), .i_half_period(hp_in[1]), .i_mode(mode_in[1]),
        .i_heartbeat(hb), .o_gate(gate_o[1]), .o_alive(alive_o[1]), .o_range_err(err_o[1]),
        .o_state(state_o[1]), .o_period_cnt(pcnt_o[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Position within a full period (0 .. 2*hp-1) replaces cnt/phase.
    int          m_st   [2];
    int          m_pos  [2];
    int          m_hp   [2];
    logic        m_mode [2];
    logic        m_err  [2];
    logic [31:0] m_pcnt [2];
    logic [3:0]  m_gate [2];
    bit          m_seen;
    int          m_n;
    logic        m_prev;
    bit          started;
    bit          alive_pre;

    function automatic logic [3:0] exp_gate(input int pos, input int hpv, input logic md, input int dt);
        bit         in_b;
        int         c;
        bit         on;
        logic [3:0] g;
        in_b = (pos >= hpv);
        c    = in_b ? pos - hpv : pos;
        on   = (c >= dt);
        g    = 4'b0000;
        if (md) begin
            g[3] = 1'b1;
            if (in_b) g[1] = on;
            else      g[0] = on;
        end else if (in_b) begin
            g = on ? 4'b0110 : 4'b0000;
        end else begin
            g = on ? 4'b1001 : 4'b0000;
        end
        return g;
    endfunction

    task automatic model_step(input int i, input bit alv);
        int         dt;
        bit         was_act;
        logic [3:0] g;
        dt      = (i == 0) ? DT0 : DT1;
        was_act = (m_st[i] == 1) || (m_st[i] == 2);
        g       = exp_gate(m_pos[i], m_hp[i], m_mode[i], dt);
        if (!nrst) begin
            m_st[i] = 0; m_pos[i] = 0; m_err[i] = 1'b0; m_pcnt[i] = '0; m_gate[i] = 4'b0000;
            return;
        end
        case (m_st[i])
            0: if (en[i] && alv) begin
                   if (dt < int'(hp_in[i])) begin
                       m_st[i] = 1; m_hp[i] = int'(hp_in[i]); m_mode[i] = mode_in[i]; m_pos[i] = 0;
                   end else begin
                       m_err[i] = 1'b1;
                   end
               end
            1, 2: if (!alv) begin
                      m_st[i] = 3;
                  end else begin
                      m_pos[i]++;
                      if (m_pos[i] == 2 * m_hp[i]) begin
                          m_pos[i] = 0;
                          m_pcnt[i]++;
                          if (m_st[i] == 2 || !en[i]) begin
                              m_st[i] = 0; m_err[i] = 1'b0;
                          end else if (dt < int'(hp_in[i])) begin
                              m_hp[i] = int'(hp_in[i]);
                          end else begin
                              m_err[i] = 1'b1;
                          end
                      end else if (m_st[i] == 1 && !en[i]) begin
                          m_st[i] = 2;
                      end
                  end
            3: if (!en[i] && alv) begin
                   m_st[i] = 0; m_err[i] = 1'b0;
               end
            default: ;
        endcase
        if (m_st[i] != 1 && m_st[i] != 2) m_pos[i] = 0;
        m_gate[i] = (was_act && (m_st[i] == 1 || m_st[i] == 2)) ? g : 4'b0000;
    endtask

    // Model advances on the same edge as the DUT, from the inputs held since the last falling edge.
    always @(posedge clk) begin
        alive_pre = m_seen && (m_n <= HB_T);
        for (int i = 0; i < 2; i++) model_step(i, alive_pre);
        if (!nrst) begin
            m_seen = 1'b0; m_n = 0; started = 1'b1;
        end else if (hb != m_prev) begin
            m_seen = 1'b1; m_n = 0;
        end else if (m_n < 1000000) begin
            m_n++;
        end
        m_prev = hb;
    end

    // Cycle-by-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("state%0d", i), state_o[i], m_st[i]);
                check($sformatf("gate%0d", i), gate_o[i], m_gate[i]);
                check($sformatf("alive%0d", i), alive_o[i], (m_seen && (m_n <= HB_T)) ? 1 : 0);
                check($sformatf("range_err%0d", i), err_o[i], m_err[i]);
                check($sformatf("period_cnt%0d", i), pcnt_o[i], m_pcnt[i]);
                check($sformatf("shoot_through%0d", i),
                      (gate_o[i][0] & gate_o[i][1]) | (gate_o[i][2] & gate_o[i][3]), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit hb_run;
    int hb_cnt;
    int w1001, w0110, w0000, w_pc;
    int w_h1, w_h2, w_h3, w_h4;

    task automatic tick();
        @(negedge clk);
        if (hb_run) begin
            if (hb_cnt == 49) begin
                hb = ~hb; hb_cnt = 0;
            end else begin
                hb_cnt++;
            end
        end
    endtask

    task automatic wait_state(input int i, input int st, input int budget, input string name);
        int k;
        k = 0;
        while (int'(state_o[i]) != st && k < budget) begin
            tick();
            k++;
        end
        check(name, state_o[i], st);
    endtask

    task automatic measure(input int n);
        logic [31:0] pc0;
        pc0 = pcnt_o[0];
        w1001 = 0; w0110 = 0; w0000 = 0; w_h1 = 0; w_h2 = 0; w_h3 = 0; w_h4 = 0;
        repeat (n) begin
            tick();
            if (gate_o[0] == 4'b1001) w1001++;
            if (gate_o[0] == 4'b0110) w0110++;
            if (gate_o[0] == 4'b0000) w0000++;
            if (gate_o[1][0]) w_h1++;
            if (gate_o[1][1]) w_h2++;
            if (gate_o[1][2]) w_h3++;
            if (gate_o[1][3]) w_h4++;
        end
        w_pc = int'(pcnt_o[0] - pc0);
    endtask

    initial begin
        int          k;
        logic [31:0] pc0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_pos[i] = 0; m_hp[i] = 1; m_mode[i] = 1'b0;
            m_err[i] = 1'b0; m_pcnt[i] = '0; m_gate[i] = 4'b0000;
        end
        m_seen = 1'b0; m_n = 0; m_prev = 1'b0; started = 1'b0;
        nrst = 1'b0; hb = 1'b0; hb_run = 1'b0; hb_cnt = 0;
        en[0] = 1'b0; en[1] = 1'b0;
        hp_in[0] = 16'd10; hp_in[1] = 16'd8;
        mode_in[0] = 1'b0; mode_in[1] = 1'b1;

        // Reset values
        repeat (3) tick();
        check("rst_state", state_o[0], 0);
        check("rst_gate", gate_o[0], 0);
        check("rst_alive", alive_o[0], 0);
        check("rst_err", err_o[0], 0);
        check("rst_pcnt", pcnt_o[0], 0);

        // Start both bridges once the heartbeat is seen
        nrst = 1'b1; hb = 1'b1; hb_cnt = 0; hb_run = 1'b1;
        en[0] = 1'b1; en[1] = 1'b1;
        wait_state(0, 1, 10, "start_run");

        // Full-bridge hp=10 DT=4: 6 on / 4 dead per half, 20-clock period; half-bridge hp=8 DT=2
        repeat (45) tick();
        measure(80);
        check("full_s1s4", w1001, 24);
        check("full_s2s3", w0110, 24);
        check("full_off", w0000, 32);
        check("full_periods", w_pc, 4);
        check("half_s1", w_h1, 30);
        check("half_s2", w_h2, 30);
        check("half_s3", w_h3, 0);
        check("half_s4", w_h4, 80);

        // Invalid half-period is refused at the boundary, old 10 kept
        hp_in[0] = 16'd3;
        repeat (45) tick();
        check("bad_hp_err", err_o[0], 1);
        measure(80);
        check("keep_s1s4", w1001, 24);
        check("keep_s2s3", w0110, 24);
        check("keep_periods", w_pc, 4);

        // New half-period 16 taken at the next boundary
        hp_in[0] = 16'd16;
        repeat (50) tick();
        measure(96);
        check("hp16_s1s4", w1001, 36);
        check("hp16_s2s3", w0110, 36);
        check("hp16_off", w0000, 24);
        check("hp16_periods", w_pc, 3);
        check("err_sticky", err_o[0], 1);

        // Stop request at cnt=2 of phase A; re-enable during STOP must not cancel it
        k = 0;
        while (!(m_st[0] == 1 && m_pos[0] == 2) && k < 64) begin
            tick();
            k++;
        end
        en[0] = 1'b0;
        pc0 = pcnt_o[0];
        repeat (5) tick();
        check("stopping", state_o[0], 2);
        en[0] = 1'b1;
        repeat (5) tick();
        check("stop_not_aborted", state_o[0], 2);
        en[0] = 1'b0;
        wait_state(0, 0, 80, "stop_to_idle");
        check("stop_periods", pcnt_o[0] - pc0, 1);
        check("stop_gate", gate_o[0], 0);
        check("stop_clears_err", err_o[0], 0);

        // Heartbeat loss: alive drops 102 falling edges after the last toggle, then FAULT
        en[0] = 1'b1; hp_in[0] = 16'd10;
        wait_state(0, 1, 10, "restart");
        repeat (30) tick();
        hb = ~hb; hb_run = 1'b0;
        k = 0;
        while (alive_o[0] && k < 300) begin
            tick();
            k++;
        end
        check("wdt_clocks", k, 102);
        check("fault_pending", state_o[0], 1);
        tick();
        check("fault_state", state_o[0], 3);
        check("fault_gate", gate_o[0], 0);
        hb = ~hb;
        repeat (5) tick();
        check("fault_hold_alive", alive_o[0], 1);
        check("fault_hold_en", state_o[0], 3);
        en[0] = 1'b0;
        repeat (2) tick();
        check("fault_exit", state_o[0], 0);

        // One-clock reset mid-RUN
        en[0] = 1'b1; hb = ~hb; hb_cnt = 0; hb_run = 1'b1;
        wait_state(0, 1, 10, "rerun");
        repeat (25) tick();
        hb_run = 1'b0;
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("mid_rst_state", state_o[0], 0);
        check("mid_rst_gate", gate_o[0], 0);
        check("mid_rst_pcnt", pcnt_o[0], 0);
        check("mid_rst_alive", alive_o[0], 0);
        check("mid_rst_err", err_o[0], 0);
        check("mid_rst_state1", state_o[1], 0);
        repeat (5) tick();
        check("no_start_without_hb", state_o[0], 0);
        hb = ~hb; hb_cnt = 0; hb_run = 1'b1;
        repeat (3) tick();
        check("start_after_hb", state_o[0], 1);

        repeat (20) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
